// File: rtl/multiplexor_arb_20_16x1.sv
// 16-to-1 word multiplexor with round-robin arbitration and packet locking.
// A registered output stage gives 1-cycle latency and sustains one word per cycle.
module multiplexor_arb_20_16x1 #(
  parameter int WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           in_valid,
  input  logic [15:0]           in_last,
  input  logic [16*WIDTH-1:0]   in_data,
  output logic [15:0]           in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [3:0]            out_addr,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       ptr_reg, ptr_next;
  logic [3:0]       lock_src_reg, lock_src_next;
  logic [3:0]       sel;
  logic [15:0]      cand;
  logic             space;
  logic             load;
  logic             found;
  logic [WIDTH-1:0] word [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
      assign word[gi] = in_data[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Candidate search starts at ptr and wraps; in LOCK only the owner can win.
  always_comb begin
    logic [3:0] idx;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    space = !out_valid || out_ready;
    cand  = (state_reg == LOCK) ? (in_valid & (16'd1 << lock_src_reg)) : in_valid;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_reg + 4'(i);
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    // Reset forces in_ready low immediately so no source believes it was accepted.
    load     = !rst && space && found;
    in_ready = load ? (16'd1 << sel) : 16'd0;
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lock_src_next = lock_src_reg;
    if (load) begin
      if (in_last[sel]) begin
        state_next = ARB;
        ptr_next   = sel + 4'd1;
      end else begin
        state_next    = LOCK;
        lock_src_next = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      lock_src_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lock_src_reg <= lock_src_next;
    end
  end

  // Output stage: a load replaces the held word even while it is being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= in_last[sel];
      out_addr  <= sel;
      out_data  <= word[sel];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplexor_arb_20_16x1.sv
// Bench for multiplexor_arb_20_16x1: directed vector table, hand sequences for reset,
// round robin and wrap, then random traffic against a behavioural arbiter model.
module tb_multiplexor_arb_20_16x1;

  localparam int W = 20;

  logic            clk;
  logic            rst;
  logic [15:0]     in_valid;
  logic [15:0]     in_last;
  logic [16*W-1:0] in_data;
  logic [15:0]     in_ready;
  logic            out_valid;
  logic            out_last;
  logic [3:0]      out_addr;
  logic [W-1:0]    out_data;
  logic            out_ready;

  multiplexor_arb_20_16x1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_addr(out_addr),
    .out_data(out_data), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who owns the sink, where the round-robin scan starts, what is held.
  int          m_ptr;
  int          m_lock;
  logic        m_valid;
  logic        m_last;
  logic [3:0]  m_addr;
  logic [W-1:0] m_data;

  typedef struct {
    logic [15:0] v;
    logic [15:0] l;
    logic        ordy;
    logic [15:0] exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_addr;
    logic        exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_valid = 0; m_last = 0; m_addr = 0; m_data = '0;
  endtask

  // Winner this cycle, or -1 when nobody is accepted.
  function automatic int pick();
    if (m_valid && !out_ready) return -1;
    if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < 16; k++)
      if (in_valid[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
    return -1;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
  task automatic step(input logic [15:0] v, input logic [15:0] l, input logic ordy,
                      output logic [15:0] rdy_seen);
    int g;
    logic [15:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    for (int i = 0; i < 16; i++) in_data[i*W +: W] = W'($urandom);
    #1;
    g = pick();
    exp_rdy = (g >= 0) ? (16'd1 << g) : 16'd0;
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_addr  = 4'(g);
      m_data  = in_data[g*W +: W];
      m_last  = in_last[g];
      if (in_last[g]) begin
        m_lock = -1;
        m_ptr  = (g + 1) % 16;
      end else begin
        m_lock = g;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_addr",  32'(out_addr),  32'(m_addr));
    chk("out_last",  32'(out_last),  32'(m_last));
    chk("out_data",  32'(out_data),  32'(m_data));
  endtask

  vec_t        tbl [18];
  logic [15:0] rdy;

  initial begin
    tbl[0]  = '{16'h0020, 16'h0020, 1'b1, 16'h0020, 1'b1, 4'd5,  1'b1};
    tbl[1]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd5,  1'b1};
    tbl[2]  = '{16'h4000, 16'h4000, 1'b1, 16'h4000, 1'b1, 4'd14, 1'b1};
    tbl[3]  = '{16'h8002, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b1};
    tbl[4]  = '{16'h0002, 16'hFFFF, 1'b1, 16'h0002, 1'b1, 4'd1,  1'b1};
    tbl[5]  = '{16'h000C, 16'h0000, 1'b1, 16'h0004, 1'b1, 4'd2,  1'b0};
    tbl[6]  = '{16'h000C, 16'h0000, 1'b1, 16'h0004, 1'b1, 4'd2,  1'b0};
    tbl[7]  = '{16'h0008, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2,  1'b0};
    tbl[8]  = '{16'h0008, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2,  1'b0};
    tbl[9]  = '{16'h000C, 16'h0004, 1'b1, 16'h0004, 1'b1, 4'd2,  1'b1};
    tbl[10] = '{16'h0008, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3,  1'b1};
    tbl[11] = '{16'h0080, 16'h0080, 1'b1, 16'h0080, 1'b1, 4'd7,  1'b1};
    tbl[12] = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 4'd7,  1'b1};
    tbl[13] = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 4'd7,  1'b1};
    tbl[14] = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 4'd7,  1'b1};
    tbl[15] = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 4'd7,  1'b1};
    tbl[16] = '{16'h0080, 16'h0080, 1'b1, 16'h0080, 1'b1, 4'd7,  1'b1};
    tbl[17] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd7,  1'b1};

    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: single source, wrap 14->15->1, packet lock with idle owner, backpressure.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].ordy, rdy);
      chk($sformatf("tbl%0d_rdy", i),  32'(rdy),       32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_ov", i),   32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_addr", i), 32'(out_addr),  32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_last", i), 32'(out_last),  32'(tbl[i].exp_last));
    end

    // Reset in the middle of a locked packet with ptr at 10.
    step(16'h0200, 16'h0200, 1'b1, rdy);
    step(16'h0400, 16'h0000, 1'b1, rdy);
    chk("pre_rst_lock_addr", 32'(out_addr), 32'd10);
    @(negedge clk);
    in_valid = 16'h0408; in_last = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_addr",  32'(out_addr),  32'd0);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(16'h0408, 16'hFFFF, 1'b1, rdy);
    chk("post_rst_grant", 32'(rdy), 32'h0008);
    chk("post_rst_addr",  32'(out_addr), 32'd3);

    // Round robin with every source valid: ptr starts at 4, 17 back-to-back grants.
    for (int k = 0; k < 17; k++) begin
      step(16'hFFFF, 16'hFFFF, 1'b1, rdy);
      chk($sformatf("rr%0d_rdy", k),  32'(rdy),       32'(16'd1 << ((4 + k) % 16)));
      chk($sformatf("rr%0d_addr", k), 32'(out_addr),  32'((4 + k) % 16));
      chk($sformatf("rr%0d_ov", k),   32'(out_valid), 32'd1);
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(16'($urandom & $urandom), 16'($urandom), 1'(($urandom % 4) != 0), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
